// File: rtl/qpu_mcu_issue.sv
// qpu_mcu_issue: timed event issue from a shared timepoint/event FIFO with measurement result writeback
module qpu_mcu_issue #(
   parameter int TIME_W    = 32,
   parameter int EVENT_W   = 8,
   parameter int EVENT_NUM = 4,
   parameter int QUBIT_NUM = 4,
   parameter int DEPTH     = 8,
   parameter int MAX_MEAS  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tiq_i_ena,
   output logic                 tiq_i_ready,
   input  logic [TIME_W-1:0]    tiq_i_data,
   input  logic                 evq_i_ena,
   output logic                 evq_i_ready,
   input  logic [EVENT_W-1:0]   evq_i_data,
   input  logic [EVENT_NUM-1:0] evq_i_oprand,
   input  logic                 evq_i_measure,
   output logic                 mcu_o_valid,
   output logic [EVENT_W-1:0]   mcu_o_event,
   output logic [EVENT_NUM-1:0] mcu_o_oprand,
   output logic                 mcu_o_measure,
   input  logic                 mcu_i_result_valid,
   input  logic [QUBIT_NUM-1:0] mcu_i_result,
   output logic                 mcu_o_wen,
   output logic [QUBIT_NUM-1:0] mcu_o_measurement,
   output logic                 busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = EVENT_W + EVENT_NUM + 1;
   localparam int PW = TIME_W > EW ? TIME_W : EW;
   localparam int CW = $clog2(MAX_MEAS + 1);
   typedef enum logic [1:0] {IDLE, POP, WAIT, MSTALL} state_t;
   logic [PW:0] mem_q [DEPTH];
   logic [PW:0] wdata, head;
   logic [AW:0] wp_q, wp_d, rp_q, rp_d;
   state_t state_q, state_d;
   logic [TIME_W-1:0] wcnt_q, wcnt_d;
   logic [CW-1:0] mcnt_q, mcnt_d;
   logic valid_q, valid_d, measure_q, measure_d, wen_q, wen_d;
   logic [EVENT_W-1:0] event_q, event_d;
   logic [EVENT_NUM-1:0] oprand_q, oprand_d;
   logic [QUBIT_NUM-1:0] meas_q, meas_d;
   logic full, empty, push, pop, res_acc, head_ev, head_meas, meas_cap;
   assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign empty = wp_q == rp_q;
   assign tiq_i_ready = ~full;
   assign evq_i_ready = ~full & ~tiq_i_ena;
   assign push = (tiq_i_ena & tiq_i_ready) | (evq_i_ena & evq_i_ready);
   assign wdata = tiq_i_ena ? {1'b0, PW'(tiq_i_data)} : {1'b1, PW'({evq_i_data, evq_i_oprand, evq_i_measure})};
   assign head = mem_q[rp_q[AW-1:0]];
   assign head_ev = head[PW];
   assign head_meas = head[0];
   assign meas_cap = mcnt_q == CW'(MAX_MEAS);
   assign res_acc = mcu_i_result_valid & (mcnt_q != '0);
   always_comb begin
      state_d = state_q;
      wcnt_d = wcnt_q;
      pop = 1'b0;
      valid_d = 1'b0;
      event_d = event_q;
      oprand_d = oprand_q;
      measure_d = measure_q;
      case (state_q)
         IDLE: state_d = empty ? IDLE : POP;
         POP: begin
            if (empty) state_d = IDLE;
            else if (!head_ev) begin
               pop = 1'b1;
               if (head[TIME_W-1:0] != '0) begin
                  wcnt_d = head[TIME_W-1:0] - 1'b1;
                  state_d = WAIT;
               end
            end else if (head_meas && meas_cap) state_d = MSTALL;
            else begin
               pop = 1'b1;
               valid_d = 1'b1;
               {event_d, oprand_d, measure_d} = head[EW-1:0];
            end
         end
         WAIT: begin
            wcnt_d = wcnt_q == '0 ? wcnt_q : wcnt_q - 1'b1;
            state_d = wcnt_q != '0 ? WAIT : empty ? IDLE : POP;
         end
         default: state_d = meas_cap ? MSTALL : POP;
      endcase
      wp_d = wp_q + (AW + 1)'(push);
      rp_d = rp_q + (AW + 1)'(pop);
      mcnt_d = mcnt_q + CW'(valid_d & head_meas) - CW'(res_acc);
      wen_d = res_acc;
      meas_d = res_acc ? mcu_i_result : meas_q;
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q[AW-1:0]] <= wdata;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wp_q <= '0;
         rp_q <= '0;
         wcnt_q <= '0;
         mcnt_q <= '0;
         valid_q <= 1'b0;
         event_q <= '0;
         oprand_q <= '0;
         measure_q <= 1'b0;
         wen_q <= 1'b0;
         meas_q <= '0;
      end else begin
         state_q <= state_d;
         wp_q <= wp_d;
         rp_q <= rp_d;
         wcnt_q <= wcnt_d;
         mcnt_q <= mcnt_d;
         valid_q <= valid_d;
         event_q <= event_d;
         oprand_q <= oprand_d;
         measure_q <= measure_d;
         wen_q <= wen_d;
         meas_q <= meas_d;
      end
   end
   assign mcu_o_valid = valid_q;
   assign mcu_o_event = event_q;
   assign mcu_o_oprand = oprand_q;
   assign mcu_o_measure = measure_q;
   assign mcu_o_wen = wen_q;
   assign mcu_o_measurement = meas_q;
   assign busy = ~empty | (state_q != IDLE) | (mcnt_q != '0);
endmodule

// File: tb/tb_qpu_mcu_issue.sv
// tb_qpu_mcu_issue: directed self-checking bench for qpu_mcu_issue
module tb_qpu_mcu_issue;
   logic clk = 1'b0, rst = 1'b1;
   logic tiq_i_ena = 1'b0, tiq_i_ready;
   logic [31:0] tiq_i_data = '0;
   logic evq_i_ena = 1'b0, evq_i_ready, evq_i_measure = 1'b0;
   logic [7:0] evq_i_data = '0;
   logic [3:0] evq_i_oprand = '0;
   logic mcu_o_valid, mcu_o_measure, mcu_o_wen, busy;
   logic [7:0] mcu_o_event;
   logic [3:0] mcu_o_oprand, mcu_o_measurement;
   logic mcu_i_result_valid = 1'b0;
   logic [3:0] mcu_i_result = '0;
   int checks = 0, failures = 0;
   int cyc, nv, first_at, last_at;
   logic [7:0] codes[$];
   qpu_mcu_issue dut (
      .clk(clk), .rst(rst),
      .tiq_i_ena(tiq_i_ena), .tiq_i_ready(tiq_i_ready), .tiq_i_data(tiq_i_data),
      .evq_i_ena(evq_i_ena), .evq_i_ready(evq_i_ready), .evq_i_data(evq_i_data),
      .evq_i_oprand(evq_i_oprand), .evq_i_measure(evq_i_measure),
      .mcu_o_valid(mcu_o_valid), .mcu_o_event(mcu_o_event), .mcu_o_oprand(mcu_o_oprand),
      .mcu_o_measure(mcu_o_measure), .mcu_i_result_valid(mcu_i_result_valid),
      .mcu_i_result(mcu_i_result), .mcu_o_wen(mcu_o_wen),
      .mcu_o_measurement(mcu_o_measurement), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (mcu_o_valid) begin
         nv++;
         codes.push_back(mcu_o_event);
         last_at = cyc;
         if (nv == 1) first_at = cyc;
      end
   endtask
   task automatic clr();
      cyc = 0; nv = 0; first_at = -1; last_at = -1;
      codes.delete();
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic wr_tp(input logic [31:0] n);
      tiq_i_ena = 1'b1; tiq_i_data = n;
      tick();
      tiq_i_ena = 1'b0;
   endtask
   task automatic wr_ev(input logic [7:0] c, input logic [3:0] m, input logic meas);
      evq_i_ena = 1'b1; evq_i_data = c; evq_i_oprand = m; evq_i_measure = meas;
      tick();
      evq_i_ena = 1'b0;
   endtask
   task automatic result(input logic [3:0] r);
      mcu_i_result_valid = 1'b1; mcu_i_result = r;
      tick();
      mcu_i_result_valid = 1'b0;
   endtask
   initial begin
      clr();
      run(2);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_valid", mcu_o_valid, 0);
      chk("rst_wen", mcu_o_wen, 0);
      chk("rst_meas", mcu_o_measurement, 0);
      chk("rst_tiq_ready", tiq_i_ready, 1);
      chk("rst_evq_ready", evq_i_ready, 1);
      tiq_i_ena = 1'b1;
      #1;
      chk("rst_evq_ready_conflict", evq_i_ready, 0);
      tiq_i_ena = 1'b0;
      clr();
      wr_tp(3);
      wr_ev(8'h5A, 4'b0001, 1'b0);
      run(10);
      chk("tp3_count", nv, 1);
      chk("tp3_when", first_at, 7);
      chk("tp3_code", codes[0], 8'h5A);
      chk("tp3_hold_event", mcu_o_event, 8'h5A);
      chk("tp3_hold_oprand", mcu_o_oprand, 4'b0001);
      chk("tp3_idle", busy, 0);
      clr();
      wr_ev(8'hA1, 4'h1, 1'b0);
      wr_ev(8'hA2, 4'h2, 1'b0);
      wr_ev(8'hA3, 4'h4, 1'b0);
      run(6);
      chk("b2b_count", nv, 3);
      chk("b2b_first", first_at, 3);
      chk("b2b_last", last_at, 5);
      chk("b2b_c0", codes[0], 8'hA1);
      chk("b2b_c1", codes[1], 8'hA2);
      chk("b2b_c2", codes[2], 8'hA3);
      chk("b2b_oprand", mcu_o_oprand, 4'h4);
      clr();
      tiq_i_ena = 1'b1; tiq_i_data = 0;
      evq_i_ena = 1'b1; evq_i_data = 8'h77; evq_i_oprand = 4'h8; evq_i_measure = 1'b0;
      #1;
      chk("conf_evq_ready", evq_i_ready, 0);
      chk("conf_tiq_ready", tiq_i_ready, 1);
      tick();
      tiq_i_ena = 1'b0;
      #1;
      chk("conf_evq_ready_next", evq_i_ready, 1);
      tick();
      evq_i_ena = 1'b0;
      run(6);
      chk("conf_count", nv, 1);
      chk("conf_when", first_at, 4);
      chk("conf_code", codes[0], 8'h77);
      clr();
      wr_tp(40);
      run(2);
      for (int i = 0; i < 8; i++) wr_ev(8'h10 + 8'(i), 4'(i), 1'b0);
      evq_i_ena = 1'b1; evq_i_data = 8'hEE;
      #1;
      chk("full_evq_ready", evq_i_ready, 0);
      chk("full_tiq_ready", tiq_i_ready, 0);
      tick();
      evq_i_ena = 1'b0;
      chk("full_busy", busy, 1);
      run(60);
      chk("full_count", nv, 8);
      chk("full_first", first_at, 44);
      for (int i = 0; i < 8; i++) chk($sformatf("full_c%0d", i), codes[i], 8'h10 + 8'(i));
      clr();
      for (int i = 0; i < 5; i++) wr_ev(8'h81 + 8'(i), 4'hF, 1'b1);
      run(7);
      chk("ms_count", nv, 4);
      chk("ms_c3", codes[3], 8'h84);
      chk("ms_busy", busy, 1);
      result(4'b1010);
      chk("ms_wen", mcu_o_wen, 1);
      chk("ms_meas", mcu_o_measurement, 4'b1010);
      tick();
      chk("ms_wen_drop", mcu_o_wen, 0);
      chk("ms_valid_wait", mcu_o_valid, 0);
      chk("ms_meas_hold", mcu_o_measurement, 4'b1010);
      tick();
      chk("ms_valid5", mcu_o_valid, 1);
      chk("ms_code5", mcu_o_event, 8'h85);
      chk("ms_measure5", mcu_o_measure, 1);
      for (int i = 0; i < 4; i++) result(4'(i));
      tick();
      chk("ms_drained", busy, 0);
      result(4'b0101);
      chk("zero_wen", mcu_o_wen, 0);
      chk("zero_meas", mcu_o_measurement, 4'd3);
      clr();
      wr_ev(8'h91, 4'h1, 1'b1);
      wr_ev(8'h92, 4'h2, 1'b1);
      tick();
      result(4'b0011);
      chk("same_valid", mcu_o_valid, 1);
      chk("same_code", mcu_o_event, 8'h92);
      chk("same_wen", mcu_o_wen, 1);
      chk("same_meas", mcu_o_measurement, 4'b0011);
      run(2);
      chk("same_busy", busy, 1);
      result(4'b1100);
      chk("same_wen2", mcu_o_wen, 1);
      chk("same_meas2", mcu_o_measurement, 4'b1100);
      tick();
      chk("same_idle", busy, 0);
      clr();
      wr_tp(100);
      wr_ev(8'hC3, 4'h3, 1'b0);
      run(5);
      chk("rw_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rw_busy0", busy, 0);
      chk("rw_valid", mcu_o_valid, 0);
      chk("rw_wen", mcu_o_wen, 0);
      chk("rw_event", mcu_o_event, 0);
      chk("rw_meas", mcu_o_measurement, 0);
      chk("rw_tiq_ready", tiq_i_ready, 1);
      clr();
      run(120);
      chk("rw_no_issue", nv, 0);
      chk("rw_still_idle", busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
